// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the SBUS memory bank phase
// Purpose: FSM state encoding, quadword request-mask type and the
//          lowest-set-bit picker used to walk sparse RQ masks.
// Ports:   none (package).
package mem_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, WDAT} memState;

  // Bit i of the mask requests word (start offset + i) mod 4; bit 0 is served first.
  typedef logic [0:3] rqMask;

  // Index of the lowest-numbered set bit; 0 when the mask is empty.
  function automatic logic [1:0] firstBit(input rqMask m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - read-data delay line from ACKN to VALID
// Purpose: delays {valid, data, parity} by RD_LAT cycles (0 = combinational
//          pass-through). Outputs are forced to zero while not valid.
// Ports:   clk, i_crobar (sync reset, clears every stage),
//          i_valid/i_data (word read this cycle),
//          o_valid/o_data/o_par (delayed word, parity = XOR of data).
module mem_rd_pipe #(
  parameter int WIDTH  = 36,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             i_crobar,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_par
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             par;
  } stage_t;

  stage_t w_in;
  stage_t w_out;

  // Idle slots carry zeros so the output gating below is belt and braces.
  always_comb begin
    w_in.valid = i_valid;
    w_in.data  = i_valid ? i_data : '0;
    w_in.par   = i_valid & (^i_data);
  end

  generate
    if (RD_LAT == 0) begin : g_comb
      assign w_out = w_in;
    end else begin : g_reg
      stage_t r_stage [RD_LAT];

      always_ff @(posedge clk) begin
        if (i_crobar) begin
          for (int k = 0; k < RD_LAT; k++) r_stage[k] <= '0;
        end else begin
          r_stage[0] <= w_in;
          for (int k = 1; k < RD_LAT; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign w_out = r_stage[RD_LAT-1];
    end
  endgenerate

  assign o_valid = w_out.valid;
  assign o_data  = w_out.valid ? w_out.data : '0;
  assign o_par   = w_out.valid & w_out.par;

endmodule

// File: rtl/mem_bank_ctl.sv
// rtl/mem_bank_ctl.sv - one interleave phase of the MB20 SBUS memory bank
// Purpose: serves SBUS quadword read and write cycles with sparse RQ masks,
//          configurable read latency, back-to-back read overlap and sticky
//          parity / nonexistent-memory error flags.
// Ports:   clk, CROBAR (sync active-high reset);
//          SBUS side: START, RD_RQ, WR_RQ, ADR, RQ, D_IN, PAR_IN, WVALID,
//          ERR_CLR in; ACKN, VALID, D_OUT, PAR_OUT, ERR_PAR, ERR_NXM out;
//          RAM side: ram_addr, ram_wdata, ram_we out; ram_rdata in
//          (combinational, same-cycle read).
//          ADR bit 0 is SBUS ADR[35]; ADR[1:0] is the starting word offset.
module mem_bank_ctl
  import mem_pkg::*;
#(
  parameter int WIDTH      = 36,
  parameter int ADR_W      = 22,
  parameter int DEPTH_LOG2 = 18,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  CROBAR,
  input  logic                  START,
  input  logic                  RD_RQ,
  input  logic                  WR_RQ,
  input  logic [ADR_W-1:0]      ADR,
  input  rqMask                 RQ,
  input  logic [WIDTH-1:0]      D_IN,
  input  logic                  PAR_IN,
  input  logic                  WVALID,
  input  logic                  ERR_CLR,
  output logic                  ACKN,
  output logic                  VALID,
  output logic [WIDTH-1:0]      D_OUT,
  output logic                  PAR_OUT,
  output logic                  ERR_PAR,
  output logic                  ERR_NXM,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_we
);

  memState               r_state;
  memState               w_state_nxt;
  // Only the RAM-backed part of the quadword address is kept; anything
  // above it is rejected as NXM before it could be latched.
  logic [DEPTH_LOG2-3:0] r_base;
  logic [1:0]            r_wo;
  logic [1:0]            r_wword;
  rqMask                 r_mask;
  rqMask                 w_mask_nxt;
  rqMask                 w_mask_served;
  logic                  r_err_par;
  logic                  r_err_nxm;

  logic [1:0]            w_idx;
  logic [1:0]            w_word;
  logic                  w_start_ok;
  logic                  w_start_nxm;
  logic                  w_par_ok;
  logic                  w_eval_start;
  logic                  w_accept;
  logic                  w_set_par;
  logic                  w_set_nxm;
  logic                  w_rd_push;

  // Word served this cycle: offset wraps inside the quadword, base is fixed.
  assign w_idx       = firstBit(r_mask);
  assign w_word      = r_wo + w_idx;
  assign w_start_ok  = START & (RD_RQ | WR_RQ) & (RQ != '0);
  assign w_start_nxm = (ADR[ADR_W-1:DEPTH_LOG2] != '0);
  assign w_par_ok    = ((^D_IN) == PAR_IN);

  always_comb begin
    w_mask_served        = r_mask;
    w_mask_served[w_idx] = 1'b0;
  end

  // State register plus the cycle context it owns.
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_base    <= '0;
      r_wo      <= '0;
      r_wword   <= '0;
      r_err_par <= 1'b0;
      r_err_nxm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      if (w_accept) begin
        r_base <= ADR[DEPTH_LOG2-1:2];
        r_wo   <= ADR[1:0];
      end
      // WDAT needs the address of the word acknowledged in WR.
      if (r_state == WR) r_wword <= w_word;
      // A set event beats a simultaneous clear.
      r_err_par <= w_set_par | (r_err_par & ~ERR_CLR);
      r_err_nxm <= w_set_nxm | (r_err_nxm & ~ERR_CLR);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_eval_start = 1'b0;
    w_accept     = 1'b0;
    w_set_par    = 1'b0;
    w_set_nxm    = 1'b0;

    case (r_state)
      IDLE: w_eval_start = 1'b1;
      RD: begin
        w_mask_nxt = w_mask_served;
        // Last read word: a new START is taken in this same cycle so the
        // next cycle's ACKN follows without a gap.
        if (w_mask_served == '0) begin
          w_state_nxt  = IDLE;
          w_eval_start = 1'b1;
        end
      end
      WR: begin
        w_mask_nxt  = w_mask_served;
        w_state_nxt = WDAT;
      end
      WDAT: begin
        // Missing data or bad parity both drop the word and flag it.
        if (!(WVALID && w_par_ok)) w_set_par = 1'b1;
        w_state_nxt = (r_mask != '0) ? WR : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_eval_start && w_start_ok) begin
      if (w_start_nxm) begin
        // No ACKN for nonexistent memory; the requester times out.
        w_set_nxm   = 1'b1;
        w_state_nxt = IDLE;
        w_mask_nxt  = '0;
      end else begin
        w_accept    = 1'b1;
        w_mask_nxt  = RQ;
        // Read-pause-write is handled as a plain read.
        w_state_nxt = RD_RQ ? RD : WR;
      end
    end
  end

  // Output logic.
  always_comb begin
    ACKN      = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    w_rd_push = 1'b0;

    case (r_state)
      RD: begin
        ACKN      = 1'b1;
        ram_addr  = {r_base, w_word};
        w_rd_push = 1'b1;
      end
      WR: begin
        ACKN     = 1'b1;
        ram_addr = {r_base, w_word};
      end
      WDAT: begin
        ram_addr = {r_base, r_wword};
        // A reset arriving in this cycle aborts the write.
        if (WVALID && w_par_ok && !CROBAR) begin
          ram_we    = 1'b1;
          ram_wdata = D_IN;
        end
      end
      default: ;
    endcase
  end

  mem_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .i_crobar (CROBAR),
    .i_valid  (w_rd_push),
    .i_data   (ram_rdata),
    .o_valid  (VALID),
    .o_data   (D_OUT),
    .o_par    (PAR_OUT)
  );

  assign ERR_PAR = r_err_par;
  assign ERR_NXM = r_err_nxm;

endmodule

// File: tb/tb_mem_bank_ctl.sv
// tb/tb_mem_bank_ctl.sv - self-checking bench for mem_bank_ctl
module tb_mem_bank_ctl;
  import mem_pkg::*;

  localparam int W  = 36;
  localparam int AW = 22;
  localparam int DL = 10;
  localparam int L1 = 1;
  localparam int NW = 1 << DL;

  logic          clk;
  logic          CROBAR, crobar2, START, start2, RD_RQ, WR_RQ;
  logic [AW-1:0] ADR;
  rqMask         RQ;
  logic [W-1:0]  D_IN;
  logic          PAR_IN, WVALID, ERR_CLR;

  logic          ACKN, VALID, PAR_OUT, ERR_PAR, ERR_NXM, ram_we;
  logic [W-1:0]  D_OUT, ram_rdata, ram_wdata;
  logic [DL-1:0] ram_addr;
  logic          ackn2, valid2, par2, errp2, errn2, ram_we2;
  logic [W-1:0]  dout2, ram_rdata2, ram_wdata2;
  logic [DL-1:0] ram_addr2;

  logic [W-1:0]  ram     [NW];
  logic [W-1:0]  ref_mem [NW];
  logic          pl_we;
  logic [DL-1:0] pl_addr;
  logic [W-1:0]  pl_data;
  bit            m_err_par, m_err_nxm;

  logic          s_ack, s_vld, s_par, s_errp, s_errn, s_we;
  logic [W-1:0]  s_dout, s_wdata;
  logic [DL-1:0] s_addr;
  logic          s2_ack, s2_vld, s2_par, s2_errp, s2_errn, s2_we;
  logic [W-1:0]  s2_dout, s2_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_bank_ctl #(.WIDTH(W), .ADR_W(AW), .DEPTH_LOG2(DL), .RD_LAT(L1)) u_dut (
    .clk(clk), .CROBAR(CROBAR), .START(START), .RD_RQ(RD_RQ), .WR_RQ(WR_RQ),
    .ADR(ADR), .RQ(RQ), .D_IN(D_IN), .PAR_IN(PAR_IN), .WVALID(WVALID),
    .ERR_CLR(ERR_CLR), .ACKN(ACKN), .VALID(VALID), .D_OUT(D_OUT),
    .PAR_OUT(PAR_OUT), .ERR_PAR(ERR_PAR), .ERR_NXM(ERR_NXM),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata),
    .ram_we(ram_we));

  mem_bank_ctl #(.WIDTH(W), .ADR_W(AW), .DEPTH_LOG2(DL), .RD_LAT(2)) u_lat2 (
    .clk(clk), .CROBAR(crobar2), .START(start2), .RD_RQ(RD_RQ), .WR_RQ(WR_RQ),
    .ADR(ADR), .RQ(RQ), .D_IN(D_IN), .PAR_IN(PAR_IN), .WVALID(WVALID),
    .ERR_CLR(ERR_CLR), .ACKN(ackn2), .VALID(valid2), .D_OUT(dout2),
    .PAR_OUT(par2), .ERR_PAR(errp2), .ERR_NXM(errn2),
    .ram_addr(ram_addr2), .ram_rdata(ram_rdata2), .ram_wdata(ram_wdata2),
    .ram_we(ram_we2));

  assign ram_rdata  = ram[ram_addr];
  assign ram_rdata2 = ram[ram_addr2];

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish (tests %0d)", n_tests);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    s_ack = ACKN; s_vld = VALID; s_dout = D_OUT; s_par = PAR_OUT;
    s_errp = ERR_PAR; s_errn = ERR_NXM; s_we = ram_we; s_wdata = ram_wdata;
    s_addr = ram_addr;
    s2_ack = ackn2; s2_vld = valid2; s2_dout = dout2; s2_par = par2;
    s2_errp = errp2; s2_errn = errn2; s2_we = ram_we2; s2_wdata = ram_wdata2;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Word addresses a cycle visits, in service order.
  task automatic words_of(input logic [AW-1:0] a, input rqMask q, inout logic [DL-1:0] lst[$]);
    logic [1:0] w;
    for (int i = 0; i < 4; i++) begin
      if (q[i]) begin
        w = 2'((a % 4) + i);
        lst.push_back(DL'((a / 4) * 4 + w));
      end
    end
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a1, input rqMask q1,
                         input bit two, input logic [AW-1:0] a2, input rqMask q2);
    logic [DL-1:0] adrs[$];
    logic [W-1:0]  exp_d;
    bit            exp_ack, exp_vld;
    int            n1, n;
    adrs = {};
    words_of(a1, q1, adrs);
    n1 = adrs.size();
    if (two) words_of(a2, q2, adrs);
    n = adrs.size();
    WR_RQ = 1'b0; WVALID = 1'b0;
    START = 1'b1; RD_RQ = 1'b1; ADR = a1; RQ = q1;
    step();
    check({tag, ".ack0"}, 64'(s_ack), 64'd0);
    for (int c = 1; c <= n + L1 + 1; c++) begin
      if (two && c <= n1) begin
        START = 1'b1; RD_RQ = 1'b1; ADR = a2; RQ = q2;
      end else begin
        START = 1'b0; RD_RQ = 1'b0;
      end
      step();
      exp_ack = (c <= n);
      exp_vld = (c > L1) && (c <= n + L1);
      exp_d   = exp_vld ? ref_mem[adrs[c-1-L1]] : '0;
      check($sformatf("%s.ack[%0d]", tag, c), 64'(s_ack), 64'(exp_ack));
      check($sformatf("%s.vld[%0d]", tag, c), 64'(s_vld), 64'(exp_vld));
      check($sformatf("%s.dout[%0d]", tag, c), 64'(s_dout), 64'(exp_d));
      check($sformatf("%s.par[%0d]", tag, c), 64'(s_par), 64'(^exp_d));
      if (exp_ack) check($sformatf("%s.addr[%0d]", tag, c), 64'(s_addr), 64'(adrs[c-1]));
    end
  endtask

  // wv/bp/dat are indexed by service order; dat==0 selects random data.
  task automatic do_write(input string tag, input logic [AW-1:0] a, input rqMask q,
                          input logic [3:0] wv, input logic [3:0] bp, input bit clr,
                          input logic [4*W-1:0] dat);
    logic [DL-1:0] adrs[$];
    logic [W-1:0]  d;
    bit            good;
    adrs = {};
    words_of(a, q, adrs);
    RD_RQ = 1'b0; START = 1'b1; WR_RQ = 1'b1; ADR = a; RQ = q;
    step();
    START = 1'b0; WR_RQ = 1'b0;
    check({tag, ".ack0"}, 64'(s_ack), 64'd0);
    for (int k = 0; k < adrs.size(); k++) begin
      step();
      check($sformatf("%s.ack[%0d]", tag, k), 64'(s_ack), 64'd1);
      check($sformatf("%s.addr[%0d]", tag, k), 64'(s_addr), 64'(adrs[k]));
      d = (dat == '0) ? rnd_word() : dat[W*k +: W];
      D_IN = d; WVALID = wv[k]; PAR_IN = (^d) ^ bp[k]; ERR_CLR = clr;
      good = wv[k] && !bp[k];
      step();
      check($sformatf("%s.we[%0d]", tag, k), 64'(s_we), 64'(good));
      check($sformatf("%s.wack[%0d]", tag, k), 64'(s_ack), 64'd0);
      if (good) begin
        check($sformatf("%s.wdata[%0d]", tag, k), 64'(s_wdata), 64'(d));
        ref_mem[adrs[k]] = d;
      end
      m_err_par = !good || (m_err_par && !clr);
      WVALID = 1'b0; ERR_CLR = 1'b0;
    end
    step();
    check({tag, ".end_ack"}, 64'(s_ack), 64'd0);
    check({tag, ".end_we"}, 64'(s_we), 64'd0);
    check({tag, ".errp"}, 64'(s_errp), 64'(m_err_par));
  endtask

  task automatic do_nxm(input string tag, input logic [AW-1:0] a, input rqMask q);
    START = 1'b1; RD_RQ = 1'b1; WR_RQ = 1'b0; ADR = a; RQ = q;
    step();
    START = 1'b0; RD_RQ = 1'b0;
    m_err_nxm = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("%s.ack[%0d]", tag, c), 64'(s_ack), 64'd0);
      check($sformatf("%s.errn[%0d]", tag, c), 64'(s_errn), 64'd1);
    end
  endtask

  task automatic clr_errs(input string tag);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    step();
    m_err_par = 1'b0; m_err_nxm = 1'b0;
    check({tag, ".errp"}, 64'(s_errp), 64'd0);
    check({tag, ".errn"}, 64'(s_errn), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a1, a2;
    rqMask         q1, q2;
    logic [3:0]    wv, bp;
    int            r;

    CROBAR = 1'b1; crobar2 = 1'b1; START = 1'b0; start2 = 1'b0;
    RD_RQ = 1'b0; WR_RQ = 1'b0; ADR = '0; RQ = '0; D_IN = '0;
    PAR_IN = 1'b0; WVALID = 1'b0; ERR_CLR = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    m_err_par = 1'b0; m_err_nxm = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backdoor fill of the RAM and the reference image.
    for (int i = 0; i < NW + 4; i++) begin
      pl_we   = 1'b1;
      pl_addr = (i < NW) ? DL'(i) : DL'(8'o100 + (i - NW));
      pl_data = (i < NW) ? rnd_word() : W'(i - NW + 1);
      ref_mem[pl_addr] = pl_data;
      @(posedge clk);
      #1;
    end
    pl_we = 1'b0;

    step();
    CROBAR = 1'b0; crobar2 = 1'b0;
    step();
    check("rst.ackn",  64'(s_ack),  64'd0);
    check("rst.valid", 64'(s_vld),  64'd0);
    check("rst.dout",  64'(s_dout), 64'd0);
    check("rst.par",   64'(s_par),  64'd0);
    check("rst.errp",  64'(s_errp), 64'd0);
    check("rst.errn",  64'(s_errn), 64'd0);
    check("rst.we",    64'(s_we),   64'd0);
    check("rst.addr",  64'(s_addr), 64'd0);

    do_read("t1", 22'o100, 4'b1111, 1'b0, '0, '0);
    do_read("t2", 22'o102, 4'b1010, 1'b0, '0, '0);

    do_write("t3", 22'o200, 4'b0011, 4'hF, 4'h0, 1'b0,
             {72'd0, 36'o456, 36'o123});
    do_read("t3rd", 22'o200, 4'b0011, 1'b0, '0, '0);

    do_write("t4", 22'o300, 4'b1100, 4'hF, 4'b0010, 1'b0, '0);
    do_read("t4rd", 22'o300, 4'b1100, 1'b0, '0, '0);
    check("t4.errp_held", 64'(s_errp), 64'd1);
    clr_errs("t4clr");

    do_write("setwin", 22'o310, 4'b1000, 4'h0, 4'h0, 1'b1, '0);
    clr_errs("setwin_clr");

    do_nxm("t5nxm", 22'(NW), 4'b1111);
    clr_errs("t5clr");
    do_read("last", 22'(NW - 1), 4'b1000, 1'b0, '0, '0);
    do_read("ovl", 22'o100, 4'b1111, 1'b1, 22'o104, 4'b1111);

    // START with an empty mask is ignored.
    START = 1'b1; RD_RQ = 1'b1; ADR = 22'o100; RQ = '0;
    step();
    START = 1'b0; RD_RQ = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("rq0.ack[%0d]", c), 64'(s_ack), 64'd0);
    end

    // Reset in the second ACKN cycle of a 4-word read on the RD_LAT=2 phase.
    RD_RQ = 1'b1; ADR = 22'o100; RQ = 4'b1111; start2 = 1'b1;
    step();
    start2 = 1'b0; RD_RQ = 1'b0;
    step();
    check("t6.ack1", 64'(s2_ack), 64'd1);
    crobar2 = 1'b1;
    step();
    crobar2 = 1'b0;
    step();
    check("t6.ack_after", 64'(s2_ack),  64'd0);
    check("t6.vld_after", 64'(s2_vld),  64'd0);
    check("t6.d_after",   64'(s2_dout), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t6.stray_vld[%0d]", c), 64'(s2_vld), 64'd0);
      check($sformatf("t6.stray_ack[%0d]", c), 64'(s2_ack), 64'd0);
    end
    RD_RQ = 1'b1; ADR = 22'o101; RQ = 4'b1000; start2 = 1'b1;
    step();
    start2 = 1'b0; RD_RQ = 1'b0;
    step();
    check("t6.re_ack", 64'(s2_ack), 64'd1);
    step();
    check("t6.re_vld_early", 64'(s2_vld), 64'd0);
    step();
    check("t6.re_vld",  64'(s2_vld),  64'd1);
    check("t6.re_dout", 64'(s2_dout), 64'(ref_mem[10'o101]));
    check("t6.re_par",  64'(s2_par),  64'(^ref_mem[10'o101]));
    check("t6.we",      64'(s2_we),   64'd0);
    check("t6.wdata",   64'(s2_wdata), 64'd0);
    check("t6.errs",    64'({s2_errp, s2_errn}), 64'd0);

    // Random traffic against the reference image.
    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 9);
      a1 = AW'($urandom_range(0, NW - 1));
      a2 = AW'($urandom_range(0, NW - 1));
      q1 = 4'($urandom_range(1, 15));
      q2 = 4'($urandom_range(1, 15));
      if (r == 0) begin
        do_nxm($sformatf("rnd%0d.nxm", it), AW'($urandom_range(NW, (1 << AW) - 1)), q1);
      end else if (r <= 5) begin
        do_read($sformatf("rnd%0d.rd", it), a1, q1, bit'($urandom_range(0, 1)), a2, q2);
      end else begin
        wv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        bp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        do_write($sformatf("rnd%0d.wr", it), a1, q1, wv, bp, 1'b0, '0);
      end
      check($sformatf("rnd%0d.errp", it), 64'(s_errp), 64'(m_err_par));
      check($sformatf("rnd%0d.errn", it), 64'(s_errn), 64'(m_err_nxm));
      if ($urandom_range(0, 3) == 0) clr_errs($sformatf("rnd%0d.clr", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
